// File: rtl/ball_engine.sv
// ball_engine: breakout ball mover with wall/paddle/floor resolution, brick probe handshake,
// serve, speed-up, lives and game-over sequencing.
module ball_engine #(
    parameter int XW           = 10,
    parameter int YW           = 10,
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120,
    parameter int PADDLE_Y     = 110,
    parameter int PADDLE_HALF  = 16,
    parameter int STEP_MAX     = 4,
    parameter int SPEEDUP_HITS = 4,
    parameter int LIVES        = 3,
    localparam int LW          = $clog2(LIVES + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          tick_i,
    input  logic          serve_i,
    input  logic [XW-1:0] paddle_x_i,
    input  logic          brick_hit_i,
    output logic [XW-1:0] ball_x_o,
    output logic [YW-1:0] ball_y_o,
    output logic [XW-1:0] probe_x_o,
    output logic [YW-1:0] probe_y_o,
    output logic          probe_valid_o,
    output logic          brick_clear_o,
    output logic          lost_o,
    output logic [LW-1:0] lives_o,
    output logic [2:0]    speed_o,
    output logic          game_over_o
);
    localparam int HW = $clog2(SPEEDUP_HITS + 1);
    localparam logic signed [XW:0] X_MAX   = (XW+1)'(SCREEN_W - 1);
    localparam logic signed [YW:0] Y_PAD   = (YW+1)'(PADDLE_Y);
    localparam logic signed [YW:0] Y_FLOOR = (YW+1)'(SCREEN_H - 1);
    localparam logic [XW-1:0] X_EDGE = XW'(SCREEN_W - 1);
    localparam logic [XW-1:0] HALF   = XW'(PADDLE_HALF);
    localparam logic [YW-1:0] Y_REST = YW'(PADDLE_Y - 1);
    localparam logic [2:0]    SMAX   = 3'(STEP_MAX);
    localparam logic [HW-1:0] HMAX   = HW'(SPEEDUP_HITS);
    localparam logic [LW-1:0] LMAX   = LW'(LIVES);

    typedef enum logic [2:0] {IDLE, RUN, PROBE, RESOLVE, LOSE, OVER} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d, cx_q, cx_d;
    logic [YW-1:0] y_q, y_d, cy_q, cy_d;
    logic          dx_q, dx_d, dy_q, dy_d, ph_q, ph_d;
    logic [2:0]    speed_q, speed_d;
    logic [HW-1:0] hit_q, hit_d;
    logic [LW-1:0] lives_q, lives_d;

    logic signed [XW:0] sx;
    logic signed [YW:0] sy;
    logic [XW-1:0]      ccx, diff;
    logic [YW-1:0]      ccy;
    logic               x_wall, ph, fl, brk;

    // dx=1 moves right, dy=1 moves down; signed one-bit-wider math keeps walls wrap-free
    assign sx     = dx_q ? $signed({1'b0, x_q}) + $signed({{(XW-2){1'b0}}, speed_q})
                         : $signed({1'b0, x_q}) - $signed({{(XW-2){1'b0}}, speed_q});
    assign sy     = dy_q ? $signed({1'b0, y_q}) + $signed({{(YW-2){1'b0}}, speed_q})
                         : $signed({1'b0, y_q}) - $signed({{(YW-2){1'b0}}, speed_q});
    assign x_wall = sx[XW] || sx > X_MAX;
    assign ccx    = sx[XW] ? '0 : (sx > X_MAX ? X_EDGE : sx[XW-1:0]);
    assign ccy    = sy[YW] ? '0 : sy[YW-1:0];
    assign diff   = ccx >= paddle_x_i ? ccx - paddle_x_i : paddle_x_i - ccx;
    assign ph     = dy_q && sy >= Y_PAD && diff <= HALF;
    assign fl     = dy_q && !ph && sy >= Y_FLOOR;
    assign brk    = brick_hit_i && !ph_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        ph_d    = ph_q;
        speed_d = speed_q;
        hit_d   = hit_q;
        lives_d = lives_q;
        case (state_q)
            IDLE: begin
                x_d = paddle_x_i;
                y_d = Y_REST;
                if (serve_i) begin
                    state_d = RUN;
                    dx_d    = 1'b1;
                    dy_d    = 1'b0;
                end
            end
            RUN: if (tick_i) begin
                cx_d    = ccx;
                cy_d    = ph ? Y_REST : ccy;
                dx_d    = dx_q ^ x_wall;
                dy_d    = dy_q ^ (sy[YW] | ph);
                ph_d    = ph;
                state_d = fl ? LOSE : PROBE;
                if (ph) begin
                    hit_d   = hit_q + 1'b1 == HMAX ? '0 : hit_q + 1'b1;
                    speed_d = hit_q + 1'b1 == HMAX && speed_q < SMAX ? speed_q + 1'b1 : speed_q;
                end
            end
            PROBE: state_d = RESOLVE;
            RESOLVE: begin
                x_d     = cx_q;
                y_d     = brk ? y_q : cy_q;
                dy_d    = dy_q ^ brk;
                state_d = RUN;
            end
            LOSE: begin
                lives_d = lives_q - 1'b1;
                if (lives_q == LW'(1)) state_d = OVER;
                else begin
                    state_d = IDLE;
                    x_d     = paddle_x_i;
                    y_d     = Y_REST;
                    dx_d    = 1'b1;
                    dy_d    = 1'b0;
                    speed_d = 3'd1;
                    hit_d   = '0;
                end
            end
            OVER: state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            x_q     <= paddle_x_i;
            y_q     <= Y_REST;
            cx_q    <= '0;
            cy_q    <= '0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b0;
            ph_q    <= 1'b0;
            speed_q <= 3'd1;
            hit_q   <= '0;
            lives_q <= LMAX;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            ph_q    <= ph_d;
            speed_q <= speed_d;
            hit_q   <= hit_d;
            lives_q <= lives_d;
        end
    end

    assign ball_x_o      = x_q;
    assign ball_y_o      = y_q;
    assign probe_x_o     = cx_q;
    assign probe_y_o     = cy_q;
    assign probe_valid_o = state_q == PROBE;
    assign brick_clear_o = state_q == RESOLVE && brk;
    assign lost_o        = state_q == LOSE;
    assign lives_o       = lives_q;
    assign speed_o       = speed_q;
    assign game_over_o   = state_q == OVER;
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed trajectories with hand-derived ball positions for serve, walls,
// corner, paddle speed-up, brick bounce, floor loss, game over and mid-flight reset.
module tb_ball_engine;
    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, serve = 1'b0, brick_hit = 1'b0;
    logic [9:0] paddle_x = 10'd80;
    logic [9:0] ball_x, ball_y, probe_x, probe_y;
    logic       probe_valid, brick_clear, lost, game_over;
    logic [1:0] lives;
    logic [2:0] speed;
    int checks = 0, failures = 0;
    int pv_n, bc_n, lost_n, px, py, mid_x;

    ball_engine dut (
        .clk_i(clk), .reset_i(reset), .tick_i(tick), .serve_i(serve),
        .paddle_x_i(paddle_x), .brick_hit_i(brick_hit),
        .ball_x_o(ball_x), .ball_y_o(ball_y), .probe_x_o(probe_x), .probe_y_o(probe_y),
        .probe_valid_o(probe_valid), .brick_clear_o(brick_clear), .lost_o(lost),
        .lives_o(lives), .speed_o(speed), .game_over_o(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int ex, input int ey);
        chk({tag, "_x"}, int'(ball_x), ex);
        chk({tag, "_y"}, int'(ball_y), ey);
    endtask

    // one frame tick followed by the full 3-cycle probe/resolve window
    task automatic step_tick(input logic brk, input logic track);
        pv_n = 0; bc_n = 0; lost_n = 0;
        @(negedge clk);
        tick = 1'b1;
        brick_hit = brk;
        if (track) paddle_x = ball_x;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick = 1'b0;
            pv_n += int'(probe_valid);
            bc_n += int'(brick_clear);
            lost_n += int'(lost);
            if (i == 1) mid_x = int'(ball_x);
            if (probe_valid) begin
                px = int'(probe_x);
                py = int'(probe_y);
            end
        end
        brick_hit = 1'b0;
    endtask

    task automatic ticks(input int n, input logic track);
        repeat (n) step_tick(1'b0, track);
    endtask

    task automatic do_serve(input int p, input int far, input logic with_tick);
        @(negedge clk);
        paddle_x = 10'(p);
        serve = 1'b1;
        tick = with_tick;
        @(negedge clk);
        serve = 1'b0;
        tick = 1'b0;
        paddle_x = 10'(far);
    endtask

    task automatic run_to_loss(input int exp_k, input string tag);
        int k = 0;
        lost_n = 0;
        while (lost_n == 0 && k < 400) begin
            k++;
            step_tick(1'b0, 1'b0);
        end
        chk(tag, k, exp_k);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_ball("rst_ball", 80, 109);
        chk("rst_lives", int'(lives), 3);
        chk("rst_speed", int'(speed), 1);
        chk("rst_over", int'(game_over), 0);
        chk("rst_pulses", int'({probe_valid, brick_clear, lost}), 0);
        chk("rst_probe", int'(probe_x) + int'(probe_y), 0);
        reset = 1'b0;

        // serve from 80: ball travels up-right at speed 1, bounces off right and top walls
        do_serve(80, 120, 1'b0);
        step_tick(1'b0, 1'b0);
        chk_ball("tick1", 81, 108);
        chk("tick1_latency", mid_x, 80);
        chk("tick1_pv", pv_n, 1);
        chk("tick1_bc", bc_n, 0);
        chk("tick1_probe", px * 1000 + py, 81108);
        ticks(77, 1'b0);
        step_tick(1'b0, 1'b0); chk_ball("k79", 159, 30);
        step_tick(1'b0, 1'b0); chk_ball("k80_rwall", 159, 29);
        step_tick(1'b0, 1'b0); chk_ball("k81", 158, 28);
        ticks(27, 1'b0);
        step_tick(1'b0, 1'b0); chk_ball("k109", 130, 0);
        step_tick(1'b0, 1'b0); chk_ball("k110_top", 129, 0);
        step_tick(1'b0, 1'b0); chk_ball("k111", 128, 1);
        ticks(116, 1'b0);
        step_tick(1'b0, 1'b0); chk_ball("k228", 11, 118);
        step_tick(1'b0, 1'b0);
        chk("floor_lost", lost_n, 1);
        chk("floor_pv", pv_n, 0);
        chk("floor_lives", int'(lives), 2);
        chk_ball("floor_idle", 120, 109);
        chk("floor_over", int'(game_over), 0);

        // brick bounce on the way down
        do_serve(80, 120, 1'b0);
        ticks(149, 1'b0);
        chk_ball("b149", 90, 39);
        step_tick(1'b1, 1'b0);
        chk("brick_bc", bc_n, 1);
        chk("brick_probe", px * 1000 + py, 89040);
        chk_ball("brick", 89, 39);
        step_tick(1'b0, 1'b0);
        chk_ball("brick_next", 88, 38);
        chk("brick_bc_after", bc_n, 0);
        run_to_loss(158, "b_loss_tick");
        chk("b_lives", int'(lives), 1);

        // reset while in PROBE with one life left
        do_serve(80, 120, 1'b0);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chk("c_in_probe", int'(probe_valid), 1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("c_pv", int'(probe_valid), 0);
        chk("c_lives", int'(lives), 3);
        chk("c_over", int'(game_over), 0);
        chk("c_speed", int'(speed), 1);
        chk("c_probe", int'(probe_x) + int'(probe_y), 0);
        chk_ball("c_ball", 120, 109);

        // serve with a simultaneous tick; paddle then tracks the ball for a long rally
        do_serve(50, 50, 1'b1);
        repeat (3) @(negedge clk);
        chk_ball("e_serve_tick", 50, 109);
        ticks(108, 1'b1);
        step_tick(1'b0, 1'b1); chk_ball("e109", 159, 0);
        step_tick(1'b0, 1'b1); chk_ball("e110_corner", 159, 0);
        step_tick(1'b0, 1'b1); chk_ball("e111", 158, 1);
        ticks(107, 1'b1);
        step_tick(1'b0, 1'b1); chk_ball("e219", 50, 109);
        step_tick(1'b1, 1'b1);
        chk_ball("e220_paddle", 49, 109);
        chk("e220_bc", bc_n, 0);
        chk("e220_pv", pv_n, 1);
        step_tick(1'b0, 1'b1); chk_ball("e221", 48, 108);
        ticks(658, 1'b1); chk("spd_k879", int'(speed), 1);
        step_tick(1'b0, 1'b1); chk("spd_k880", int'(speed), 2); chk("y_k880", int'(ball_y), 109);
        ticks(439, 1'b1); chk("spd_k1319", int'(speed), 2);
        step_tick(1'b0, 1'b1); chk("spd_k1320", int'(speed), 3); chk("y_k1320", int'(ball_y), 109);
        ticks(295, 1'b1); chk("spd_k1615", int'(speed), 3);
        step_tick(1'b0, 1'b1); chk("spd_k1616", int'(speed), 4); chk("y_k1616", int'(ball_y), 109);
        ticks(224, 1'b1);
        chk("spd_sat", int'(speed), 4);
        chk("y_k1840", int'(ball_y), 109);
        chk("e_lives", int'(lives), 3);

        // three floor losses end the game
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_serve(80, 120, 1'b0);
            run_to_loss(229, "d_loss_tick");
            chk("d_lives", int'(lives), 2 - i);
        end
        chk("d_over", int'(game_over), 1);
        chk_ball("d_frozen", 11, 118);
        do_serve(80, 120, 1'b1);
        step_tick(1'b0, 1'b0);
        chk("d_pv", pv_n, 0);
        chk("d_lost", lost_n, 0);
        chk_ball("d_still", 11, 118);
        chk("d_over_sticky", int'(game_over), 1);
        chk("d_lives_end", int'(lives), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
Parametrised successor to the single-step ball mover. It owns ball position, per-axis direction and speed for the breakout playfield, and advances the ball once per frame tick. Wall, paddle, floor and brick collisions are resolved through a probe/response handshake with the brick map. It also handles serve, speed-up, lives and game-over sequencing.

Parameters:
XW, 10, coordinate width of X (ball_x, paddle_x, probe_x)
YW, 10, coordinate width of Y
SCREEN_W, 160, playfield width in pixels; legal X is 0..SCREEN_W-1
SCREEN_H, 120, playfield height; Y=0 is the top and Y grows downward
PADDLE_Y, 110, paddle row; the ball rests at PADDLE_Y-1 when served
PADDLE_HALF, 16, paddle half-width; a hit requires |cx-paddle_x| <= PADDLE_HALF
STEP_MAX, 4, maximum per-tick step per axis (speed ceiling)
SPEEDUP_HITS, 4, number of paddle hits per speed increment
LIVES, 3, lives at reset; LW = clog2(LIVES+1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  frame-advance pulse, one cycle wide
serve  in  1  launch request, one cycle wide
paddle_x  in  XW  paddle centre X
brick_hit  in  1  brick-map response for probe_x/probe_y, valid the cycle after probe_valid
ball_x  out  XW  committed ball X
ball_y  out  YW  committed ball Y
probe_x  out  XW  candidate X under query
probe_y  out  YW  candidate Y under query
probe_valid  out  1  high for one cycle (PROBE state)
brick_clear  out  1  one-cycle pulse: clear the brick at probe_x/probe_y
lost  out  1  one-cycle pulse on a floor miss
lives  out  LW  remaining lives
speed  out  3  current step size, 1..STEP_MAX
game_over  out  1  sticky until reset

Behaviour:
- Reset, synchronous and taking priority in every state:
  - state=IDLE, ball_x=paddle_x, ball_y=PADDLE_Y-1.
  - dx=+ (right), dy=- (up), speed=1, hit_cnt=0, lives=LIVES.
  - All pulse outputs 0, game_over=0, probe_x/probe_y=0.
- States: IDLE, RUN, PROBE, RESOLVE, LOSE, OVER.
- IDLE:
  - ball_x tracks paddle_x every cycle; ball_y=PADDLE_Y-1.
  - serve -> RUN with dx=+, dy=-. If serve and tick arrive in the same cycle, the tick is ignored.
- RUN: on tick, compute the candidate and go to PROBE.
  - Candidate: cx = ball_x ± speed, cy = ball_y ± speed.
  - Arithmetic uses (W+1)-bit signed intermediates, so there is no wrap-around.
- X wall handling (applied to the candidate):
  - cx<0 -> cx=0, dx flips.
  - cx>SCREEN_W-1 -> cx=SCREEN_W-1, dx flips.
- Top wall: cy<0 -> cy=0, dy flips.
- Corner: a simultaneous X and Y wall event flips both directions.
- Paddle test, applied only when dy=+ and cy>=PADDLE_Y:
  - Uses the clamped cx. |cx-paddle_x| is computed unsigned-safe, which handles paddle_x<PADDLE_HALF.
  - Within PADDLE_HALF -> cy=PADDLE_Y-1, dy flips, hit_cnt++.
  - When hit_cnt reaches SPEEDUP_HITS: hit_cnt=0, and speed++ if speed<STEP_MAX (saturating).
  - Paddle hits skip the brick check.
- Floor: dy=+, cy>=SCREEN_H-1 and no paddle hit -> LOSE. No probe is issued.
- PROBE (1 cycle): probe_valid=1 with probe_x/probe_y = candidate; next state RESOLVE.
- RESOLVE (1 cycle): sample brick_hit.
  - brick_hit=1: brick_clear=1; commit ball_x=cx; ball_y stays unchanged; dy flips.
  - brick_hit=0: commit ball_x=cx, ball_y=cy.
  - Next state RUN.
- Paddle-hit and wall-only ticks still pass through PROBE/RESOLVE. probe_valid is asserted, but brick_hit is ignored for paddle hits.
- Tick latency: ball_x/ball_y update 3 cycles after the tick (RUN->PROBE->RESOLVE->commit).
- Ticks received in PROBE, RESOLVE, LOSE or OVER are dropped, not queued.
- LOSE (1 cycle): lost=1, lives--.
  - lives becomes 0 -> OVER.
  - Otherwise -> IDLE, with speed=1 and hit_cnt=0.
- OVER: game_over=1; ball frozen; serve and tick ignored until reset.

Test Plan:
- Reset, then serve with paddle_x=80, then one tick -> after 3 cycles ball=(81,108), probe_valid pulsed once, brick_clear=0.
- Ball at (1,50), dx=-, speed=2, tick -> ball_x=0, dx=+; ball at (159,0), dx=+, dy=-, tick -> ball=(159,0) with both directions flipped.
- Ball at (70,109), dy=+, paddle_x=60, tick -> ball_y=109, dy=-; after 4 such hits speed=2; speed saturates at 4 after 12 hits.
- Ball at (100,40) moving down, brick_hit=1 in RESOLVE -> brick_clear single pulse, ball_x=101, ball_y=40, dy=-.
- Ball at (20,118) moving down, paddle_x=120 -> lost pulse, lives=2, state IDLE; repeat twice -> lives=0, game_over=1, subsequent serve/tick have no effect.
- Assert reset while in PROBE with lives=1 -> next cycle state IDLE, lives=3, probe_valid=0, game_over=0, speed=1.
